// File: rtl/mem28x32_regfile.sv
// 32 x 28-bit register-file memory for the IFFT sample banks.
// It has one synchronous write port, one combinational read port, and all 32 entries exposed in parallel.
module mem28x32_regfile #(
    parameter int DW    = 28,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] q0,
    output logic [DW-1:0] q1,
    output logic [DW-1:0] q2,
    output logic [DW-1:0] q3,
    output logic [DW-1:0] q4,
    output logic [DW-1:0] q5,
    output logic [DW-1:0] q6,
    output logic [DW-1:0] q7,
    output logic [DW-1:0] q8,
    output logic [DW-1:0] q9,
    output logic [DW-1:0] q10,
    output logic [DW-1:0] q11,
    output logic [DW-1:0] q12,
    output logic [DW-1:0] q13,
    output logic [DW-1:0] q14,
    output logic [DW-1:0] q15,
    output logic [DW-1:0] q16,
    output logic [DW-1:0] q17,
    output logic [DW-1:0] q18,
    output logic [DW-1:0] q19,
    output logic [DW-1:0] q20,
    output logic [DW-1:0] q21,
    output logic [DW-1:0] q22,
    output logic [DW-1:0] q23,
    output logic [DW-1:0] q24,
    output logic [DW-1:0] q25,
    output logic [DW-1:0] q26,
    output logic [DW-1:0] q27,
    output logic [DW-1:0] q28,
    output logic [DW-1:0] q29,
    output logic [DW-1:0] q30,
    output logic [DW-1:0] q31
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // There is no write-data bypass: the new value becomes visible only after the clock edge.
    assign rd_data = mem[rd_addr];

    assign q0  = mem[0];
    assign q1  = mem[1];
    assign q2  = mem[2];
    assign q3  = mem[3];
    assign q4  = mem[4];
    assign q5  = mem[5];
    assign q6  = mem[6];
    assign q7  = mem[7];
    assign q8  = mem[8];
    assign q9  = mem[9];
    assign q10 = mem[10];
    assign q11 = mem[11];
    assign q12 = mem[12];
    assign q13 = mem[13];
    assign q14 = mem[14];
    assign q15 = mem[15];
    assign q16 = mem[16];
    assign q17 = mem[17];
    assign q18 = mem[18];
    assign q19 = mem[19];
    assign q20 = mem[20];
    assign q21 = mem[21];
    assign q22 = mem[22];
    assign q23 = mem[23];
    assign q24 = mem[24];
    assign q25 = mem[25];
    assign q26 = mem[26];
    assign q27 = mem[27];
    assign q28 = mem[28];
    assign q29 = mem[29];
    assign q30 = mem[30];
    assign q31 = mem[31];

endmodule

// File: tb/tb_mem28x32_regfile.sv
// Self-checking bench for mem28x32_regfile.
// It runs directed scenarios and then random traffic, checked against an array model of the memory.
module tb_mem28x32_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  wr_addr;
    logic [27:0] wr_data;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [27:0] rd_data;
    logic [27:0] q [32];

    logic [27:0] model [32];
    int n_assert;
    int n_fail;

    mem28x32_regfile dut (
        .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .q0(q[0]),   .q1(q[1]),   .q2(q[2]),   .q3(q[3]),
        .q4(q[4]),   .q5(q[5]),   .q6(q[6]),   .q7(q[7]),
        .q8(q[8]),   .q9(q[9]),   .q10(q[10]), .q11(q[11]),
        .q12(q[12]), .q13(q[13]), .q14(q[14]), .q15(q[15]),
        .q16(q[16]), .q17(q[17]), .q18(q[18]), .q19(q[19]),
        .q20(q[20]), .q21(q[21]), .q22(q[22]), .q23(q[23]),
        .q24(q[24]), .q25(q[25]), .q26(q[26]), .q27(q[27]),
        .q28(q[28]), .q29(q[29]), .q30(q[30]), .q31(q[31])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s q%0d", tag, i), q[i], model[i]);
        end
    endtask

    task automatic sweep_rd(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            #1;
            check($sformatf("%s rd%0d", tag, i), rd_data, model[i]);
        end
    endtask

    // Apply one write, or a disabled attempt, at the next rising edge. The model mirrors the spec rule.
    task automatic cycle(input logic en, input logic [4:0] a, input logic [27:0] d);
        @(negedge clk);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        if (en && !rst) model[a] = d;
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset state. A write attempted while rst is high must be lost.
        #2;
        check_all("reset");
        cycle(1'b1, 5'd3, 28'h1234567);
        check_all("write_in_reset");
        @(negedge clk);
        rst = 1'b0;

        // Sequential fill
        for (int i = 0; i < 32; i++) cycle(1'b1, 5'(i), 28'h100 + 28'(i));
        check_all("fill");
        sweep_rd("fill");

        // Write disabled
        cycle(1'b0, 5'd5, 28'hFFFFFFF);
        check_all("wr_dis");

        // Read during write to the same address
        cycle(1'b1, 5'd7, 28'h0000007);
        @(negedge clk);
        rd_addr = 5'd7;
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 28'h8000001;
        #1;
        check("rdw_before", rd_data, 28'h0000007);
        @(posedge clk);
        model[7] = 28'h8000001;
        #1;
        wr_en = 1'b0;
        check("rdw_after", rd_data, 28'h8000001);
        check("rdw_q7", q[7], 28'h8000001);

        // Overwrite entry 0
        cycle(1'b1, 5'd0, 28'hABCDEF0);
        check_all("overwrite");

        // Negative data
        cycle(1'b1, 5'd31, 28'hFFFFFF6);
        check("neg_q31", q[31], 28'hFFFFFF6);
        rd_addr = 5'd31;
        #1;
        check("neg_rd31", rd_data, 28'hFFFFFF6);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            wr_en   = 1'($urandom_range(0, 3) != 0);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = 28'($urandom);
            rd_addr = 5'($urandom_range(0, 31));
            @(posedge clk);
            if (wr_en) model[wr_addr] = wr_data;
            #1;
            check("rand_rd", rd_data, model[rd_addr]);
            if (n % 50 == 49) check_all("rand");
        end
        wr_en = 1'b0;
        check_all("rand_end");

        // Mid-run reset clears everything immediately, before any clock edge.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        #1;
        check_all("midrst");
        sweep_rd("midrst");
        cycle(1'b1, 5'd9, 28'h5A5A5A5);
        check_all("midrst_wr");
        @(negedge clk);
        rst = 1'b0;

        // The memory is usable again after the reset.
        cycle(1'b1, 5'd9, 28'h0C0FFEE);
        check_all("post_rst");
        sweep_rd("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
